// File: rtl/fx2_slave_fifo_model.sv
// FX2-side model of the synchronous slave-FIFO interface: EP2 (host -> FPGA) and EP6 (FPGA -> host)
// endpoint FIFOs, FLAGA-D, split FDI/FDO data bus and a byte-stream host port standing in for USB.
module fx2_slave_fifo_model #(
  parameter int unsigned OUT_DEPTH = 512,
  parameter int unsigned IN_DEPTH  = 512,
  parameter int unsigned PKT_SIZE  = 512
) (
  input  logic       IFCLK,
  input  logic       RST,
  input  logic       SLRD,
  input  logic       SLWR,
  input  logic       SLOE,
  input  logic [1:0] ADDR,
  input  logic       PKTEND,
  input  logic [7:0] FDI,
  output logic [7:0] FDO,
  output logic       FDS,
  output logic       FLAGA,
  output logic       FLAGB,
  output logic       FLAGC,
  output logic       FLAGD,
  input  logic [7:0] h_out_data,
  input  logic       h_out_valid,
  output logic       h_out_ready,
  output logic [7:0] h_in_data,
  output logic       h_in_last,
  output logic       h_in_valid,
  input  logic       h_in_ready,
  output logic       h_in_zlp,
  output logic       proto_err
);

  localparam int unsigned OAW = $clog2(OUT_DEPTH);
  localparam int unsigned IAW = $clog2(IN_DEPTH);
  localparam int unsigned CW  = $clog2(PKT_SIZE + 1);
  localparam logic [CW-1:0] PKT_LAST = CW'(PKT_SIZE);

  logic [OAW:0]    out_wr_q, out_rd_q;
  logic [IAW:0]    in_wr_q, in_rd_q;
  logic [7:0]      out_mem [OUT_DEPTH];
  logic [7:0]      in_mem [IN_DEPTH];
  logic            in_last_mem [IN_DEPTH];
  logic [CW-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic            zlp_q, zlp_d;
  logic            err_q, err_d;

  logic out_empty, out_full, in_empty, in_full;
  logic [IAW:0] in_used;
  logic [IAW-1:0] in_prev_idx;
  logic rd_strobe, wr_strobe, pkt_end, sel_ep2, sel_ep6;
  logic out_push, out_pop, in_push, in_pop;
  logic retro, retro_clash, retro_tag, push_last, violation;
  logic [CW-1:0] cnt_inc;

  // The extra pointer bit distinguishes full from empty when the index bits match.
  assign out_empty = (out_wr_q == out_rd_q);
  assign out_full  = (out_wr_q[OAW] != out_rd_q[OAW]) && (out_wr_q[OAW-1:0] == out_rd_q[OAW-1:0]);
  assign in_empty  = (in_wr_q == in_rd_q);
  assign in_full   = (in_wr_q[IAW] != in_rd_q[IAW]) && (in_wr_q[IAW-1:0] == in_rd_q[IAW-1:0]);
  assign in_used     = in_wr_q - in_rd_q;
  assign in_prev_idx = in_wr_q[IAW-1:0] - IAW'(1);

  assign rd_strobe = ~SLRD;
  assign wr_strobe = ~SLWR;
  assign pkt_end   = ~PKTEND;
  assign sel_ep2   = (ADDR == 2'b00);
  assign sel_ep6   = (ADDR == 2'b10);

  assign out_push = h_out_valid & ~out_full;
  assign out_pop  = rd_strobe & sel_ep2 & ~out_empty;
  assign in_pop   = h_in_ready & ~in_empty;
  // A full EP6 still takes a write when the host frees a slot on the same edge.
  assign in_push  = wr_strobe & sel_ep6 & (~in_full | in_pop);

  assign cnt_inc   = pkt_cnt_q + CW'(1);
  assign push_last = pkt_end | (cnt_inc == PKT_LAST);

  // Late commit tags the newest entry, unless the host is taking that very entry right now.
  assign retro       = pkt_end & ~in_push & (pkt_cnt_q != '0);
  assign retro_clash = retro & in_pop & (in_used == (IAW + 1)'(1));
  assign retro_tag   = retro & ~retro_clash & ~in_empty;

  assign violation = (rd_strobe & ~sel_ep2)
                   | (wr_strobe & ~sel_ep6)
                   | (rd_strobe & wr_strobe)
                   | (rd_strobe & sel_ep2 & out_empty)
                   | (wr_strobe & sel_ep6 & in_full & ~in_pop)
                   | retro_clash;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pkt_cnt_d = pkt_cnt_q;
    zlp_d     = 1'b0;
    err_d     = err_q | violation;
    if (in_push) begin
      pkt_cnt_d = push_last ? '0 : cnt_inc;
    end else if (pkt_end) begin
      zlp_d     = (pkt_cnt_q == '0);
      pkt_cnt_d = '0;
    end
  end

  always_ff @(posedge IFCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (RST) begin
      out_wr_q  <= '0;
      out_rd_q  <= '0;
      in_wr_q   <= '0;
      in_rd_q   <= '0;
      pkt_cnt_q <= '0;
      zlp_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (out_push) out_wr_q <= out_wr_q + (OAW + 1)'(1);
      if (out_pop)  out_rd_q <= out_rd_q + (OAW + 1)'(1);
      if (in_push)  in_wr_q  <= in_wr_q + (IAW + 1)'(1);
      if (in_pop)   in_rd_q  <= in_rd_q + (IAW + 1)'(1);
      pkt_cnt_q <= pkt_cnt_d;
      zlp_q     <= zlp_d;
      err_q     <= err_d;
    end
  end

  // NOTE: storage arrays are not reset; the reset pointers make stale contents unreachable.
  always_ff @(posedge IFCLK) begin
    if (out_push) out_mem[out_wr_q[OAW-1:0]] <= h_out_data;
    if (in_push) begin
      in_mem[in_wr_q[IAW-1:0]]      <= FDI;
      in_last_mem[in_wr_q[IAW-1:0]] <= push_last;
    end else if (retro_tag) begin
      in_last_mem[in_prev_idx] <= 1'b1;
    end
  end

  assign FDS         = ~SLOE & sel_ep2;
  assign FDO         = out_empty ? 8'h00 : out_mem[out_rd_q[OAW-1:0]];
  assign FLAGA       = in_empty;
  assign FLAGB       = ~in_full;
  assign FLAGC       = ~out_empty;
  assign FLAGD       = out_full;
  assign h_out_ready = ~out_full;
  assign h_in_valid  = ~in_empty;
  assign h_in_data   = in_empty ? 8'h00 : in_mem[in_rd_q[IAW-1:0]];
  assign h_in_last   = in_empty ? 1'b0 : in_last_mem[in_rd_q[IAW-1:0]];
  assign h_in_zlp    = zlp_q;
  assign proto_err   = err_q;

endmodule

// File: tb/tb_fx2_slave_fifo_model.sv
// Bench for fx2_slave_fifo_model: directed scenarios plus a random phase, checked every cycle against
// a queue-based reference model of both endpoints.
module tb_fx2_slave_fifo_model;

  localparam int OUT_DEPTH = 8;
  localparam int IN_DEPTH  = 8;
  localparam int PKT_SIZE  = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } in_ent_t;

  logic       IFCLK = 1'b0;
  logic       RST, SLRD, SLWR, SLOE, PKTEND;
  logic [1:0] ADDR;
  logic [7:0] FDI, FDO, h_out_data, h_in_data;
  logic       FDS, FLAGA, FLAGB, FLAGC, FLAGD;
  logic       h_out_valid, h_out_ready, h_in_last, h_in_valid, h_in_ready, h_in_zlp, proto_err;

  logic [7:0] ep2_q[$];
  in_ent_t    ep6_q[$];
  int         pkt_cnt;
  logic       exp_zlp, exp_err;
  logic       mon_on = 1'b0;
  int         n_checks = 0;
  int         n_errs = 0;

  always #5 IFCLK = ~IFCLK;

  fx2_slave_fifo_model #(
    .OUT_DEPTH(OUT_DEPTH), .IN_DEPTH(IN_DEPTH), .PKT_SIZE(PKT_SIZE)
  ) dut (
    .IFCLK(IFCLK), .RST(RST), .SLRD(SLRD), .SLWR(SLWR), .SLOE(SLOE), .ADDR(ADDR),
    .PKTEND(PKTEND), .FDI(FDI), .FDO(FDO), .FDS(FDS),
    .FLAGA(FLAGA), .FLAGB(FLAGB), .FLAGC(FLAGC), .FLAGD(FLAGD),
    .h_out_data(h_out_data), .h_out_valid(h_out_valid), .h_out_ready(h_out_ready),
    .h_in_data(h_in_data), .h_in_last(h_in_last), .h_in_valid(h_in_valid),
    .h_in_ready(h_in_ready), .h_in_zlp(h_in_zlp), .proto_err(proto_err)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: endpoint contents as queues, updated from the rules at each rising edge.
  always @(posedge IFCLK) begin
    logic rd, wr, pe, host_pop, host_push, fpga_pop, wr_acc, retro, clash;
    in_ent_t ent;
    if (RST) begin
      ep2_q.delete();
      ep6_q.delete();
      pkt_cnt = 0;
      exp_zlp = 1'b0;
      exp_err = 1'b0;
    end else begin
      rd = !SLRD;
      wr = !SLWR;
      pe = !PKTEND;
      host_pop  = h_in_ready && (ep6_q.size() > 0);
      host_push = h_out_valid && (ep2_q.size() < OUT_DEPTH);
      fpga_pop  = rd && (ADDR == 2'b00) && (ep2_q.size() > 0);
      wr_acc    = wr && (ADDR == 2'b10) && ((ep6_q.size() < IN_DEPTH) || host_pop);
      if ((rd && ADDR != 2'b00) || (wr && ADDR != 2'b10) || (rd && wr) ||
          (rd && ADDR == 2'b00 && ep2_q.size() == 0) || (wr && ADDR == 2'b10 && !wr_acc))
        exp_err = 1'b1;
      retro = pe && !wr_acc && (pkt_cnt > 0);
      clash = retro && host_pop && (ep6_q.size() == 1);
      if (clash) exp_err = 1'b1;
      if (retro && !clash && ep6_q.size() > 0) begin
        ent = ep6_q[ep6_q.size() - 1];
        ent.last = 1'b1;
        ep6_q[ep6_q.size() - 1] = ent;
      end
      if (host_pop) void'(ep6_q.pop_front());
      exp_zlp = 1'b0;
      if (wr_acc) begin
        pkt_cnt++;
        ent.data = FDI;
        ent.last = pe || (pkt_cnt == PKT_SIZE);
        if (ent.last) pkt_cnt = 0;
        ep6_q.push_back(ent);
      end else if (pe) begin
        if (pkt_cnt == 0) exp_zlp = 1'b1;
        pkt_cnt = 0;
      end
      if (fpga_pop) void'(ep2_q.pop_front());
      if (host_push) ep2_q.push_back(h_out_data);
    end
  end

  // Monitor: compares everything the DUT presents against the model, away from the active edge.
  always @(negedge IFCLK) begin
    if (mon_on) begin
      check("FLAGA", 8'(FLAGA), 8'(ep6_q.size() == 0));
      check("FLAGB", 8'(FLAGB), 8'(ep6_q.size() < IN_DEPTH));
      check("FLAGC", 8'(FLAGC), 8'(ep2_q.size() > 0));
      check("FLAGD", 8'(FLAGD), 8'(ep2_q.size() == OUT_DEPTH));
      check("h_out_ready", 8'(h_out_ready), 8'(ep2_q.size() < OUT_DEPTH));
      check("FDS", 8'(FDS), 8'(!SLOE && ADDR == 2'b00));
      check("FDO", FDO, (ep2_q.size() > 0) ? ep2_q[0] : 8'h00);
      check("h_in_valid", 8'(h_in_valid), 8'(ep6_q.size() > 0));
      if (h_in_valid && ep6_q.size() > 0) begin
        check("h_in_data", h_in_data, ep6_q[0].data);
        check("h_in_last", 8'(h_in_last), 8'(ep6_q[0].last));
      end else begin
        check("h_in_data_idle", h_in_data, 8'h00);
        check("h_in_last_idle", 8'(h_in_last), 8'h00);
      end
      check("h_in_zlp", 8'(h_in_zlp), 8'(exp_zlp));
      check("proto_err", 8'(proto_err), 8'(exp_err));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge IFCLK);
    #2;
  endtask

  task automatic drain(output logic last_seen);
    int n = 0;
    last_seen = 1'b0;
    h_in_ready = 1'b1;
    #1;
    while (h_in_valid && n < 4 * IN_DEPTH) begin
      last_seen = h_in_last;
      tick();
      n++;
    end
    h_in_ready = 1'b0;
    check("drain_empty", 8'(h_in_valid), 8'h00);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_FLAGA"}, 8'(FLAGA), 8'h01);
    check({tag, "_FLAGB"}, 8'(FLAGB), 8'h01);
    check({tag, "_FLAGC"}, 8'(FLAGC), 8'h00);
    check({tag, "_FLAGD"}, 8'(FLAGD), 8'h00);
    check({tag, "_FDS"}, 8'(FDS), 8'h00);
    check({tag, "_FDO"}, FDO, 8'h00);
    check({tag, "_h_out_ready"}, 8'(h_out_ready), 8'h01);
    check({tag, "_h_in_valid"}, 8'(h_in_valid), 8'h00);
    check({tag, "_h_in_data"}, h_in_data, 8'h00);
    check({tag, "_proto_err"}, 8'(proto_err), 8'h00);
  endtask

  initial begin
    logic last_seen;
    int r;
    RST = 1'b1; SLRD = 1'b1; SLWR = 1'b1; SLOE = 1'b1; ADDR = 2'b11; PKTEND = 1'b1;
    FDI = 8'h00; h_out_data = 8'h00; h_out_valid = 1'b0; h_in_ready = 1'b0;
    repeat (2) tick();
    mon_on = 1'b1;
    RST = 1'b0;
    tick();
    #1 check_reset_outputs("reset");

    // Host fills EP2, FPGA reads it back through FDO.
    h_out_valid = 1'b1;
    foreach (ep2_q[i]) ;
    h_out_data = 8'h11; tick();
    h_out_data = 8'h22; tick();
    h_out_data = 8'h33; tick();
    h_out_valid = 1'b0;
    SLOE = 1'b0; ADDR = 2'b00; SLRD = 1'b0;
    #1 check("rd_fdo0", FDO, 8'h11);
    tick();
    #1 check("rd_fdo1", FDO, 8'h22);
    tick();
    #1 check("rd_fdo2", FDO, 8'h33);
    tick();
    SLRD = 1'b1; SLOE = 1'b1; ADDR = 2'b11;
    #1 check("rd_flagc_after", 8'(FLAGC), 8'h00);
    check("rd_no_err", 8'(proto_err), 8'h00);

    // FPGA writes 0xA0..0xA4 with PKTEND on the fifth byte.
    ADDR = 2'b10;
    for (int i = 0; i < 5; i++) begin
      SLWR = 1'b0; FDI = 8'hA0 + 8'(i); PKTEND = (i == 4) ? 1'b0 : 1'b1;
      tick();
    end
    SLWR = 1'b1; PKTEND = 1'b1; ADDR = 2'b11;
    drain(last_seen);
    check("pktend_last", 8'(last_seen), 8'h01);

    // Eight writes, no PKTEND: auto-commit every PKT_SIZE bytes.
    ADDR = 2'b10;
    for (int i = 0; i < 8; i++) begin
      SLWR = 1'b0; FDI = 8'($urandom); tick();
    end
    SLWR = 1'b1; ADDR = 2'b11;
    drain(last_seen);
    check("auto_last", 8'(last_seen), 8'h01);

    // PKTEND alone on an empty packet: one-cycle ZLP pulse.
    ADDR = 2'b10; PKTEND = 1'b0; tick();
    PKTEND = 1'b1; ADDR = 2'b11;
    #1 check("zlp_pulse", 8'(h_in_zlp), 8'h01);
    tick();
    #1 check("zlp_single", 8'(h_in_zlp), 8'h00);
    check("zlp_no_err", 8'(proto_err), 8'h00);

    // Fill EP6, overflow by one, then push and pop together at full.
    ADDR = 2'b10;
    for (int i = 0; i < IN_DEPTH; i++) begin
      SLWR = 1'b0; FDI = 8'h40 + 8'(i); tick();
    end
    SLWR = 1'b1;
    #1 check("full_flagb", 8'(FLAGB), 8'h00);
    check("full_no_err", 8'(proto_err), 8'h00);
    SLWR = 1'b0; FDI = 8'hEE; tick();
    SLWR = 1'b1;
    #1 check("overflow_err", 8'(proto_err), 8'h01);
    h_in_ready = 1'b1; SLWR = 1'b0; FDI = 8'h77; tick();
    h_in_ready = 1'b0; SLWR = 1'b1; ADDR = 2'b11;
    #1 check("full_pushpop_flagb", 8'(FLAGB), 8'h00);
    check("full_pushpop_flaga", 8'(FLAGA), 8'h00);

    // Reset mid-stream, then read from an empty EP2.
    RST = 1'b1; tick();
    RST = 1'b0; tick();
    #1 check_reset_outputs("rerst");
    ADDR = 2'b00; SLRD = 1'b0; tick();
    SLRD = 1'b1; ADDR = 2'b11;
    #1 check("empty_rd_err", 8'(proto_err), 8'h01);
    RST = 1'b1; tick();
    RST = 1'b0;

    // Random traffic on both endpoints.
    for (int c = 0; c < 600; c++) begin
      h_out_valid = 1'($urandom_range(0, 1));
      h_out_data  = 8'($urandom);
      h_in_ready  = ($urandom_range(0, 2) != 0);
      SLOE        = 1'($urandom_range(0, 1));
      FDI         = 8'($urandom);
      PKTEND      = ($urandom_range(0, 7) != 0);
      RST         = ($urandom_range(0, 199) == 0);
      SLRD = 1'b1; SLWR = 1'b1;
      r = int'($urandom_range(0, 9));
      if (r < 4) begin
        ADDR = 2'b00; SLRD = 1'b0;
      end else if (r < 8) begin
        ADDR = 2'b10; SLWR = 1'b0;
      end else if (r == 8) begin
        ADDR = 2'($urandom);
      end else begin
        ADDR = 2'($urandom); SLRD = 1'($urandom); SLWR = 1'($urandom);
      end
      tick();
    end
    RST = 1'b0; SLRD = 1'b1; SLWR = 1'b1; PKTEND = 1'b1; h_out_valid = 1'b0;
    tick();
    tick();
    mon_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
